// File: rtl/irq_pkg.sv
// Shared types and helpers for the external-interrupt front end.
// The FSM state type and the id-width rule live here so the controller and bench agree.
package irq_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StReq,
      StService
   } irq_state_e;

   // A single source still needs a 1-bit id.
   function automatic int unsigned id_width(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/irq_debounce.sv
// One interrupt source: synchroniser chain, debounce counter and the accepted stable level.
// rise pulses for one cycle, on the same edge where stable goes from 0 to 1.
module irq_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned SYNC_STAGES     = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic src,
   output logic stable,
   output logic rise
);

   localparam int unsigned CNT_W = (DEBOUNCE_CYCLES <= 1) ? 1 : $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [CNT_W-1:0]       cnt_q;
   logic                   stable_q;
   logic                   rise_q;
   logic                   synced;

   assign synced = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q   <= '0;
         cnt_q    <= '0;
         stable_q <= 1'b0;
         rise_q   <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], src};
         rise_q <= 1'b0;
         // A level change is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
         if (synced == stable_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CNT_MAX) begin
            stable_q <= synced;
            rise_q   <= synced;
            cnt_q    <= '0;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign stable = stable_q;
   assign rise   = rise_q;

endmodule

// File: rtl/irq_controller.sv
// External-interrupt front end: debounced sources, pending capture, fixed-priority
// arbitration and a req/ack/done handshake towards the pipeline trap logic.
module irq_controller
   import irq_pkg::*;
#(
   parameter int unsigned       N_SRC           = 4,
   parameter int unsigned       DEBOUNCE_CYCLES = 4,
   parameter int unsigned       SYNC_STAGES     = 2,
   parameter logic [N_SRC-1:0]  EDGE_MASK       = {N_SRC{1'b1}},
   parameter int unsigned       ID_W            = id_width(N_SRC)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_SRC-1:0] src_in,
   input  logic [N_SRC-1:0] en_mask,
   output logic             irq_req,
   output logic [ID_W-1:0]  irq_id,
   input  logic             irq_ack,
   input  logic             irq_done,
   output logic [N_SRC-1:0] pending_o,
   output logic             iled
);

   logic [N_SRC-1:0] stable;
   logic [N_SRC-1:0] rise;
   logic [N_SRC-1:0] pending_q, pending_d;
   logic [N_SRC-1:0] ack_clr;
   logic [N_SRC-1:0] eligible;
   logic [ID_W-1:0]  winner;
   irq_state_e       state_q;
   logic             irq_req_q;
   logic [ID_W-1:0]  irq_id_q;
   logic             iled_q;

   for (genvar g = 0; g < N_SRC; g++) begin : g_src
      irq_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .SYNC_STAGES     (SYNC_STAGES)
      ) u_debounce (
         .clk    (clk),
         .reset  (reset),
         .src    (src_in[g]),
         .stable (stable[g]),
         .rise   (rise[g])
      );
   end

   // Edge sources: a new rise wins over an ack clearing the same bit.
   always_comb begin
      ack_clr   = '0;
      pending_d = '0;
      for (int i = 0; i < N_SRC; i++) begin
         ack_clr[i] = (state_q == StReq) && irq_ack && (irq_id_q == ID_W'(i));
         if (EDGE_MASK[i]) begin
            pending_d[i] = (pending_q[i] & ~ack_clr[i]) | rise[i];
         end else begin
            pending_d[i] = stable[i];
         end
      end
   end

   assign eligible = pending_q & en_mask;

   // Descending scan so the lowest eligible index is the last one written.
   always_comb begin
      winner = '0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (eligible[i]) begin
            winner = ID_W'(i);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pending_q <= '0;
      end else begin
         pending_q <= pending_d;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= StIdle;
         irq_req_q <= 1'b0;
         irq_id_q  <= '0;
         iled_q    <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (|eligible) begin
                  state_q   <= StReq;
                  irq_req_q <= 1'b1;
                  irq_id_q  <= winner;
                  iled_q    <= 1'b1;
               end
            end
            StReq: begin
               if (irq_ack) begin
                  state_q   <= StService;
                  irq_req_q <= 1'b0;
               end
            end
            StService: begin
               if (irq_done) begin
                  state_q <= StIdle;
                  iled_q  <= 1'b0;
               end
            end
            default: begin
               state_q   <= StIdle;
               irq_req_q <= 1'b0;
               iled_q    <= 1'b0;
            end
         endcase
      end
   end

   assign irq_req   = irq_req_q;
   assign irq_id    = irq_id_q;
   assign pending_o = pending_q;
   assign iled      = iled_q;

endmodule
